// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data filter.
//   fn_e        : function codes carried on fn_sel
//   bytes_of()  : bytes per sample for a given sample width
//   log2_of()   : ceil(log2(v)), used for counter and accumulator widths
//   is_round_fn : true for functions that produce one result per round
package iotdf_pkg;

   typedef enum logic [2:0] {
      FN_IDLE = 3'd0,
      FN_MAX  = 3'd1,
      FN_MIN  = 3'd2,
      FN_AVG  = 3'd3,
      FN_EXT  = 3'd4,
      FN_EXC  = 3'd5,
      FN_PMAX = 3'd6,
      FN_PMIN = 3'd7
   } fn_e;

   function automatic int bytes_of(input int w);
      return w / 8;
   endfunction

   function automatic int log2_of(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic is_round_fn(input fn_e f);
      return (f == FN_MAX) || (f == FN_MIN) || (f == FN_AVG) ||
             (f == FN_PMAX) || (f == FN_PMIN);
   endfunction

endpackage

// File: rtl/iotdf_deser.sv
// Byte-to-sample assembler.
//   clk, rst    : clock, asynchronous active-low reset
//   cap         : a byte is accepted on this edge
//   iot_in      : byte, first byte of a sample ends up in the MSBs
//   first_byte  : the next accepted byte starts a new sample
//   last_byte   : the next accepted byte completes a sample
//   sample      : assembled sample (valid while sample_done is high)
//   sample_done : one-cycle pulse after the edge that completed a sample
module iotdf_deser
   import iotdf_pkg::*;
#(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap,
   input  logic [7:0]        iot_in,
   output logic              first_byte,
   output logic              last_byte,
   output logic [DATA_W-1:0] sample,
   output logic              sample_done
);

   localparam int NB = bytes_of(DATA_W);
   localparam int BW = log2_of(NB);

   logic [BW-1:0]     byte_cnt;
   logic [DATA_W-1:0] shreg;

   assign first_byte = (byte_cnt == '0);
   assign last_byte  = (byte_cnt == BW'(NB - 1));
   // The shift register is only read in the cycle after completion; a byte
   // captured that same edge is shifted in after the reader has sampled it.
   assign sample     = shreg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt    <= '0;
         shreg       <= '0;
         sample_done <= 1'b0;
      end else begin
         sample_done <= 1'b0;
         if (cap) begin
            shreg <= {shreg[DATA_W-9:0], iot_in};
            if (last_byte) begin
               byte_cnt    <= '0;
               sample_done <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iotdf_mf.sv
// IoT data filter: frames bytes into samples, samples into rounds of GRP,
// and computes max / min / average / band extract / band exclude /
// peak-max / peak-min results.
//   clk, rst  : clock, asynchronous active-low reset
//   in_en     : iot_in carries a byte this cycle
//   iot_in    : sample byte, MSB first
//   fn_sel    : function code, latched on the first byte of each round
//   low, high : band thresholds for extract/exclude
//   busy      : bytes offered this cycle are dropped
//   valid     : iot_out holds a fresh result this cycle
//   iot_out   : result, holds its value between results
//
// Handshake: a byte transfers on a rising edge exactly when in_en=1 and
// busy=0; with busy=1 the byte is ignored and nothing changes. valid is a
// one-cycle pulse with no back-pressure.
module iotdf_mf
   import iotdf_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int GRP    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic [7:0]        iot_in,
   input  logic [2:0]        fn_sel,
   input  logic [DATA_W-1:0] low,
   input  logic [DATA_W-1:0] high,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] iot_out
);

   localparam int LG = log2_of(GRP);
   localparam int AW = DATA_W + LG;

   logic              cap, first_byte, last_byte, sample_done;
   logic [DATA_W-1:0] sample;
   logic [LG-1:0]     sample_cnt;
   logic              round_last, round_first, in_band, take_max;
   fn_e               fn_lat, fn_in;
   logic [DATA_W-1:0] ext, ext_nxt, peak, low_q, high_q, avg;
   logic              peak_vld;
   logic [AW-1:0]     acc, acc_nxt;

   iotdf_deser #(.DATA_W(DATA_W)) u_deser (
      .clk         (clk),
      .rst         (rst),
      .cap         (cap),
      .iot_in      (iot_in),
      .first_byte  (first_byte),
      .last_byte   (last_byte),
      .sample      (sample),
      .sample_done (sample_done)
   );

   assign fn_in      = fn_e'(fn_sel);
   assign cap        = in_en & ~busy;
   assign round_last = (sample_cnt == LG'(GRP - 1));
   // Round-level results are computed on the edge after the last byte, so
   // input is stalled for that one cycle.
   assign busy       = sample_done & round_last & is_round_fn(fn_lat);
   // While a completion is pending the counter has not advanced yet, so a
   // byte arriving then starts a new round only if the pending one was last.
   assign round_first = first_byte & (sample_done ? round_last : (sample_cnt == '0));

   always_comb begin
      take_max = (fn_lat == FN_MAX) || (fn_lat == FN_PMAX);
      ext_nxt  = sample;
      if (sample_cnt != '0) begin
         if (take_max) ext_nxt = (sample > ext) ? sample : ext;
         else          ext_nxt = (sample < ext) ? sample : ext;
      end
      acc_nxt = ((sample_cnt == '0) ? '0 : acc) + AW'(sample);
      avg     = acc_nxt[AW-1:LG];
      in_band = (sample > low_q) && (sample < high_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_cnt <= '0;
         fn_lat     <= FN_IDLE;
         ext        <= '0;
         acc        <= '0;
         peak       <= '0;
         peak_vld   <= 1'b0;
         low_q      <= '0;
         high_q     <= '0;
         valid      <= 1'b0;
         iot_out    <= '0;
      end else begin
         valid <= 1'b0;
         // Thresholds belong to the edge that completes the sample.
         if (cap && last_byte) begin
            low_q  <= low;
            high_q <= high;
         end
         if (cap && round_first) begin
            fn_lat <= fn_in;
            if (fn_in != fn_lat) begin
               peak     <= '0;
               peak_vld <= 1'b0;
            end
         end
         if (sample_done) begin
            sample_cnt <= sample_cnt + 1'b1;
            ext        <= ext_nxt;
            acc        <= acc_nxt;
            case (fn_lat)
               FN_EXT: if (in_band) begin
                  iot_out <= sample;
                  valid   <= 1'b1;
               end
               FN_EXC: if (!in_band) begin
                  iot_out <= sample;
                  valid   <= 1'b1;
               end
               FN_MAX, FN_MIN: if (round_last) begin
                  iot_out <= ext_nxt;
                  valid   <= 1'b1;
               end
               FN_AVG: if (round_last) begin
                  iot_out <= avg;
                  valid   <= 1'b1;
               end
               FN_PMAX: if (round_last && (!peak_vld || ext_nxt > peak)) begin
                  iot_out  <= ext_nxt;
                  valid    <= 1'b1;
                  peak     <= ext_nxt;
                  peak_vld <= 1'b1;
               end
               FN_PMIN: if (round_last && (!peak_vld || ext_nxt < peak)) begin
                  iot_out  <= ext_nxt;
                  valid    <= 1'b1;
                  peak     <= ext_nxt;
                  peak_vld <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iotdf_mf.sv
// Bench for iotdf_mf: one instance at DATA_W=128/GRP=8 and one at
// DATA_W=32/GRP=4. A queue-based reference model predicts busy, valid and
// iot_out for every cycle of the selected instance.
module tb_iotdf_mf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         a_in_en = 1'b0, b_in_en = 1'b0;
   logic [7:0]   a_iot_in = '0, b_iot_in = '0;
   logic [2:0]   a_fn = '0, b_fn = '0;
   logic [127:0] low = '0, high = '0;
   logic         a_busy, a_valid, b_busy, b_valid;
   logic [127:0] a_out;
   logic [31:0]  b_out;

   iotdf_mf dut_a (
      .clk(clk), .rst(rst), .in_en(a_in_en), .iot_in(a_iot_in), .fn_sel(a_fn),
      .low(low), .high(high), .busy(a_busy), .valid(a_valid), .iot_out(a_out)
   );

   iotdf_mf #(.DATA_W(32), .GRP(4)) dut_b (
      .clk(clk), .rst(rst), .in_en(b_in_en), .iot_in(b_iot_in), .fn_sel(b_fn),
      .low(low[31:0]), .high(high[31:0]), .busy(b_busy), .valid(b_valid), .iot_out(b_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit           sel = 0;
   int           nb, grp;
   logic [127:0] mask;
   logic [7:0]   m_bytes[$];
   logic [127:0] m_round[$];
   logic [2:0]   m_fn;
   logic [127:0] m_pk, m_pend_val, m_last_out, obs_last_out;
   bit           m_pk_set, m_busy, m_pend;
   int           n_valid_seen = 0;
   logic [2:0]   cur_fn = 0;

   task automatic config_sel(input bit which);
      sel  = which;
      nb   = which ? 4 : 16;
      grp  = which ? 4 : 8;
      mask = which ? 128'hFFFF_FFFF : '1;
   endtask

   task automatic model_clear();
      m_bytes.delete();
      m_round.delete();
      m_fn = 0; m_pk = '0; m_pk_set = 0; m_busy = 0; m_pend = 0;
      m_pend_val = '0; m_last_out = '0; obs_last_out = '0;
   endtask

   task automatic do_reset();
      a_in_en = 0; b_in_en = 0;
      rst = 1'b0;
      #2;
      check("rst_busy_a", a_busy, 0);
      check("rst_valid_a", a_valid, 0);
      check("rst_out_a", a_out, 0);
      check("rst_busy_b", b_busy, 0);
      check("rst_valid_b", b_valid, 0);
      check("rst_out_b", {96'h0, b_out}, 0);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One clock: drive a byte, advance the model across the edge, compare.
   task automatic step(input bit en, input logic [7:0] b, input logic [2:0] fn);
      logic [127:0] s, lo, hi, mx, mn, cur_out, got_out;
      logic [135:0] sum;
      bit           cur_valid, new_busy, got_busy, got_valid;
      if (sel) begin b_in_en = en; b_iot_in = b; b_fn = fn; end
      else     begin a_in_en = en; a_iot_in = b; a_fn = fn; end
      @(posedge clk);
      cur_valid = m_pend;
      cur_out   = m_pend ? m_pend_val : m_last_out;
      m_pend    = 0;
      new_busy  = 0;
      if (en && !m_busy) begin
         if (m_bytes.size() == 0 && m_round.size() == 0) begin
            if (fn != m_fn) m_pk_set = 0;
            m_fn = fn;
         end
         m_bytes.push_back(b);
         if (m_bytes.size() == nb) begin
            s = '0;
            foreach (m_bytes[i]) s = (s << 8) | 128'(m_bytes[i]);
            m_bytes.delete();
            lo = low & mask;
            hi = high & mask;
            m_round.push_back(s);
            if (m_fn == 4 && s > lo && s < hi) begin m_pend = 1; m_pend_val = s; end
            if (m_fn == 5 && (s <= lo || s >= hi)) begin m_pend = 1; m_pend_val = s; end
            if (m_round.size() == grp) begin
               mx = '0; mn = mask; sum = '0;
               foreach (m_round[i]) begin
                  if (m_round[i] > mx) mx = m_round[i];
                  if (m_round[i] < mn) mn = m_round[i];
                  sum = sum + 136'(m_round[i]);
               end
               case (m_fn)
                  1: begin m_pend = 1; m_pend_val = mx; end
                  2: begin m_pend = 1; m_pend_val = mn; end
                  3: begin m_pend = 1; m_pend_val = 128'(sum / grp); end
                  6: if (!m_pk_set || mx > m_pk) begin
                        m_pend = 1; m_pend_val = mx; m_pk = mx; m_pk_set = 1;
                     end
                  7: if (!m_pk_set || mn < m_pk) begin
                        m_pend = 1; m_pend_val = mn; m_pk = mn; m_pk_set = 1;
                     end
                  default: ;
               endcase
               new_busy = (m_fn inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7});
               m_round.delete();
            end
         end
      end
      m_busy = new_busy;
      #1;
      got_busy  = sel ? b_busy : a_busy;
      got_valid = sel ? b_valid : a_valid;
      got_out   = sel ? {96'h0, b_out} : a_out;
      check("busy", got_busy, new_busy);
      check("valid", got_valid, cur_valid);
      check("iot_out", got_out, cur_out);
      if (got_valid) begin
         n_valid_seen++;
         obs_last_out = got_out;
      end
      m_last_out = cur_out;
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, cur_fn);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_sample(input logic [127:0] val, input logic [2:0] fn, input bit noisy);
      logic [2:0]   fnb;
      logic [127:0] t0, t1;
      cur_fn = fn;
      for (int i = 0; i < nb; i++) begin
         while (m_busy) step(0, 8'h00, fn);
         if (noisy && $urandom_range(0, 5) == 0) step(0, 8'($urandom), fn);
         if (noisy && $urandom_range(0, 15) == 0) begin
            t0 = rand128(); t1 = rand128();
            low  = (t0 < t1) ? t0 : t1;
            high = (t0 < t1) ? t1 : t0;
         end
         fnb = (noisy && $urandom_range(0, 3) == 0) ? 3'($urandom) : fn;
         step(1, val[(nb - 1 - i) * 8 +: 8], fnb);
      end
   endtask

   int           base, pos;
   int           pk_list[5] = '{5, 9, 9, 3, 12};
   logic [127:0] v, vmin, t0, t1;
   logic [2:0]   rfn;

   initial begin
      config_sel(0);
      #3;
      do_reset();

      // F1: samples 0x01..0x08 in the top byte
      base = n_valid_seen;
      for (int k = 1; k <= 8; k++) send_sample({8'(k), 120'h0}, 1, 0);
      flush(3);
      check("f1_count", n_valid_seen - base, 1);
      check("f1_value", obs_last_out, {8'h08, 120'h0});

      // F3: all ones must not overflow, then 0..7
      for (int k = 0; k < 8; k++) send_sample('1, 3, 0);
      flush(3);
      check("avg_ones", obs_last_out, '1);
      for (int k = 0; k < 8; k++) send_sample(128'(k), 3, 0);
      flush(3);
      check("avg_0to7", obs_last_out, 128'd3);

      // F4: both thresholds are exclusive
      low  = {8'h6F, {120{1'b1}}};
      high = {8'hAF, {120{1'b1}}};
      base = n_valid_seen;
      send_sample(low, 4, 0);
      send_sample({8'h70, 120'h0}, 4, 0);
      send_sample(high, 4, 0);
      for (int k = 0; k < 5; k++) send_sample(128'(k), 4, 0);
      flush(3);
      check("f4_count", n_valid_seen - base, 1);
      check("f4_value", obs_last_out, {8'h70, 120'h0});

      // F6 peak-max with round maxima 5,9,9,3,12
      base = n_valid_seen;
      for (int r = 0; r < 5; r++) begin
         pos = $urandom_range(0, 7);
         for (int j = 0; j < 8; j++) begin
            v = (j == pos) ? 128'(pk_list[r]) : 128'($urandom_range(0, pk_list[r]));
            send_sample(v, 6, 0);
         end
      end
      flush(3);
      check("f6_count", n_valid_seen - base, 3);
      check("f6_last", obs_last_out, 128'd12);

      // F7 after F6: peak cleared, first round min emitted
      base = n_valid_seen;
      vmin = '1;
      for (int j = 0; j < 8; j++) begin
         v = 128'($urandom_range(20, 40));
         if (v < vmin) vmin = v;
         send_sample(v, 7, 0);
      end
      flush(3);
      check("f7_count", n_valid_seen - base, 1);
      check("f7_value", obs_last_out, vmin);

      // Reset in the middle of a round
      for (int j = 0; j < 3; j++) send_sample(rand128(), 1, 0);
      step(1, 8'hA5, 1);
      do_reset();
      base = n_valid_seen;
      for (int j = 0; j < 8; j++) send_sample(rand128(), 1, 0);
      flush(3);
      check("rst_mid_count", n_valid_seen - base, 1);

      // Random rounds with gaps, mid-round fn changes and threshold moves
      for (int r = 0; r < 14; r++) begin
         rfn = 3'($urandom);
         t0 = rand128(); t1 = rand128();
         low  = (t0 < t1) ? t0 : t1;
         high = (t0 < t1) ? t1 : t0;
         for (int j = 0; j < 8; j++) begin
            case ($urandom_range(0, 5))
               0: v = low;
               1: v = high;
               2: v = 128'($urandom_range(0, 15));
               default: v = rand128();
            endcase
            send_sample(v, rfn, 1);
         end
         flush($urandom_range(0, 2));
      end
      flush(3);

      // Narrow instance: in_en held high across busy
      config_sel(1);
      do_reset();
      low = 128'h1000_0000; high = 128'hC000_0000;
      begin
         logic [31:0] s1[4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
         logic [31:0] s2[4] = '{32'h0A0B_0C0D, 32'h0102_0304, 32'h7F00_0000, 32'h1020_3040};
         base = n_valid_seen;
         cur_fn = 1;
         for (int k = 0; k < 4; k++)
            for (int i = 3; i >= 0; i--) step(1, s1[k][i*8 +: 8], 1);
         step(1, 8'hEE, 1);
         for (int k = 0; k < 4; k++)
            for (int i = 3; i >= 0; i--) step(1, s2[k][i*8 +: 8], 2);
         step(1, 8'hEE, 2);
         flush(3);
         check("b_count", n_valid_seen - base, 2);
         check("b_min", obs_last_out, 128'h0102_0304);
      end
      for (int c = 0; c < 480; c++) begin
         if (c % 40 == 0) cur_fn = 3'($urandom);
         if (c % 60 == 0) begin
            t0 = 128'($urandom); t1 = 128'($urandom);
            low  = (t0 < t1) ? t0 : t1;
            high = (t0 < t1) ? t1 : t0;
         end
         step(($urandom_range(0, 7) != 0), 8'($urandom), cur_fn);
      end
      flush(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
